// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by hazard_ctrl and haz_match; the forwarding option is HAZ_FWD_EN.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_HALT    = 2'd3
    } haz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EM = 2'b01;
    localparam logic [1:0] FWD_MW = 2'b10;

    localparam logic [1:0] HALT_DRAIN = 2'd3;

    // The nearest producer (EX) wins over the older one (MEM).
    function automatic logic [1:0] fwd_pick(input logic em_hit, input logic mw_hit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (em_hit) begin
            sel = FWD_EM;
        end else if (mw_hit) begin
            sel = FWD_MW;
        end
        return sel;
    endfunction

endpackage

// File: rtl/haz_match.sv
// Compares one decode-stage source operand against one producer's rd/wr_en.
// Register 0 is hardwired zero, so it never produces a match.
module haz_match
    import hazard_pkg::*;
#(
    parameter int REG_W = 3
) (
    input  logic [REG_W-1:0] i_src_idx,
    input  logic             i_src_vld,
    input  logic [REG_W-1:0] i_rd,
    input  logic             i_wr_en,
    output logic             o_match
);

    logic w_nonzero;

    assign w_nonzero = (i_src_idx != '0);
    assign o_match   = i_src_vld && i_wr_en && w_nonzero && (i_src_idx == i_rd);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data/control/structural hazards, flush, memory wait, halt drain.
// Define HAZ_FWD_EN to enable EX/MEM and MEM/WB forwarding with registered forward selects.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W       = 3,
    parameter int NSRC        = 2,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt_req,
    input  logic                  br_taken,
    input  logic                  mem_busy,
    input  logic [NSRC*REG_W-1:0] id_src_idx,
    input  logic [NSRC-1:0]       id_src_vld,
    input  logic                  ex_mem_read,
    input  logic                  ex_wr_en,
    input  logic [REG_W-1:0]      ex_rd,
    input  logic                  mem_wr_en,
    input  logic [REG_W-1:0]      mem_rd,
    output logic                  pipe_hold,
    output logic                  pc_hold,
    output logic                  fd_hold,
    output logic                  fd_nop,
    output logic                  de_nop,
    output logic [NSRC*2-1:0]     fwd_sel,
    output logic                  halted,
    output logic [1:0]            dbg_state
);

    haz_state_t r_state;
    haz_state_t r_saved;
    haz_state_t w_next;
    haz_state_t w_saved_next;
    haz_state_t w_eff;

    logic [1:0] r_flush_cnt;
    logic [1:0] w_flush_next;
    logic [1:0] r_drain;
    logic [1:0] w_drain_next;

    logic [NSRC-1:0] w_ex_hit;
    logic [NSRC-1:0] w_mem_hit;
    logic            w_load_use;
    logic            w_data_stall;

    logic w_pipe_hold;
    logic w_pc_hold;
    logic w_fd_hold;
    logic w_fd_nop;
    logic w_de_nop;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        haz_match #(.REG_W(REG_W)) u_ex (
            .i_src_idx (id_src_idx[g*REG_W +: REG_W]),
            .i_src_vld (id_src_vld[g]),
            .i_rd      (ex_rd),
            .i_wr_en   (ex_wr_en),
            .o_match   (w_ex_hit[g])
        );
        haz_match #(.REG_W(REG_W)) u_mem (
            .i_src_idx (id_src_idx[g*REG_W +: REG_W]),
            .i_src_vld (id_src_vld[g]),
            .i_rd      (mem_rd),
            .i_wr_en   (mem_wr_en),
            .o_match   (w_mem_hit[g])
        );
    end

    assign w_load_use = ex_mem_read && (|w_ex_hit);

`ifdef HAZ_FWD_EN
    assign w_data_stall = w_load_use;
`else
    // Without bypass paths any in-flight producer stalls; WB writes through the register file.
    assign w_data_stall = w_load_use || (|w_ex_hit) || (|w_mem_hit);
`endif

    // MEMWAIT is transparent once mem_busy drops: the saved state acts in that same cycle.
    assign w_eff = (r_state == ST_MEMWAIT) ? r_saved : r_state;

    always_comb begin
        w_next       = r_state;
        w_saved_next = r_saved;
        w_flush_next = r_flush_cnt;
        w_drain_next = r_drain;
        w_pipe_hold  = 1'b0;
        w_pc_hold    = 1'b0;
        w_fd_hold    = 1'b0;
        w_fd_nop     = 1'b0;
        w_de_nop     = 1'b0;

        case (w_eff)
            ST_HALT: begin
                w_pc_hold = 1'b1;
                w_fd_hold = 1'b1;
                w_de_nop  = 1'b1;
                if (r_drain != HALT_DRAIN) begin
                    w_drain_next = r_drain + 2'd1;
                end
            end

            ST_FLUSH: begin
                if (mem_busy) begin
                    w_pipe_hold  = 1'b1;
                    w_next       = ST_MEMWAIT;
                    w_saved_next = ST_FLUSH;
                end else begin
                    // Wrong-path branches, halts and data hazards are ignored here.
                    w_fd_nop     = 1'b1;
                    w_flush_next = r_flush_cnt - 2'd1;
                    w_next       = (r_flush_cnt == 2'd1) ? ST_RUN : ST_FLUSH;
                end
            end

            default: begin
                w_next = ST_RUN;
                if (halt_req && !br_taken) begin
                    w_pc_hold    = 1'b1;
                    w_fd_hold    = 1'b1;
                    w_de_nop     = 1'b1;
                    w_drain_next = 2'd0;
                    w_next       = ST_HALT;
                end else if (mem_busy) begin
                    w_pipe_hold  = 1'b1;
                    w_next       = ST_MEMWAIT;
                    w_saved_next = ST_RUN;
                end else if (br_taken) begin
                    w_fd_nop = 1'b1;
                    w_de_nop = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        w_flush_next = 2'(FLUSH_DEPTH - 1);
                        w_next       = ST_FLUSH;
                    end
                end else if (w_data_stall) begin
                    w_pc_hold = 1'b1;
                    w_fd_hold = 1'b1;
                    w_de_nop  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_saved     <= ST_RUN;
            r_flush_cnt <= 2'd0;
            r_drain     <= 2'd0;
        end else begin
            r_state     <= w_next;
            r_saved     <= w_saved_next;
            r_flush_cnt <= w_flush_next;
            r_drain     <= w_drain_next;
        end
    end

    assign pipe_hold = !rst && w_pipe_hold;
    assign pc_hold   = !rst && w_pc_hold;
    assign fd_hold   = !rst && w_fd_hold;
    assign fd_nop    = !rst && w_fd_nop;
    assign de_nop    = !rst && w_de_nop;
    // The drain counter counts HALT cycles; halted rises once HALT_DRAIN of them have passed.
    assign halted    = !rst && (r_state == ST_HALT) && (r_drain == HALT_DRAIN);
    assign dbg_state = r_state;

`ifdef HAZ_FWD_EN
    logic [NSRC*2-1:0] r_fwd_sel;
    logic [NSRC*2-1:0] w_fwd_calc;

    always_comb begin
        w_fwd_calc = '0;
        for (int s = 0; s < NSRC; s++) begin
            w_fwd_calc[s*2 +: 2] = fwd_pick(w_ex_hit[s], w_mem_hit[s]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_sel <= '0;
        end else if (w_de_nop) begin
            r_fwd_sel <= '0;
        end else if (!w_pipe_hold) begin
            r_fwd_sel <= w_fwd_calc;
        end
    end

    assign fwd_sel = r_fwd_sel;
`else
    assign fwd_sel = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (FLUSH_DEPTH=3); expectations follow HAZ_FWD_EN.
module tb_hazard_ctrl;

    localparam int REG_W       = 3;
    localparam int NSRC        = 2;
    localparam int FLUSH_DEPTH = 3;

`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  halt_req;
    logic                  br_taken;
    logic                  mem_busy;
    logic [NSRC*REG_W-1:0] id_src_idx;
    logic [NSRC-1:0]       id_src_vld;
    logic                  ex_mem_read;
    logic                  ex_wr_en;
    logic [REG_W-1:0]      ex_rd;
    logic                  mem_wr_en;
    logic [REG_W-1:0]      mem_rd;
    logic                  pipe_hold;
    logic                  pc_hold;
    logic                  fd_hold;
    logic                  fd_nop;
    logic                  de_nop;
    logic [NSRC*2-1:0]     fwd_sel;
    logic                  halted;
    logic [1:0]            dbg_state;

    logic [9:0] obs;
    logic [9:0] exp_q[$];
    string      name_q[$];
    logic [9:0] e_cur;
    string      n_cur;
    int         n_tests;
    int         n_fail;

    hazard_ctrl #(
        .REG_W       (REG_W),
        .NSRC        (NSRC),
        .FLUSH_DEPTH (FLUSH_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt_req    (halt_req),
        .br_taken    (br_taken),
        .mem_busy    (mem_busy),
        .id_src_idx  (id_src_idx),
        .id_src_vld  (id_src_vld),
        .ex_mem_read (ex_mem_read),
        .ex_wr_en    (ex_wr_en),
        .ex_rd       (ex_rd),
        .mem_wr_en   (mem_wr_en),
        .mem_rd      (mem_rd),
        .pipe_hold   (pipe_hold),
        .pc_hold     (pc_hold),
        .fd_hold     (fd_hold),
        .fd_nop      (fd_nop),
        .de_nop      (de_nop),
        .fwd_sel     (fwd_sel),
        .halted      (halted),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign obs = {pipe_hold, pc_hold, fd_hold, fd_nop, de_nop, halted, fwd_sel};

    // ---------------- expected-vector helpers ----------------
    function automatic logic [9:0] ev(input logic ph, input logic pc, input logic fh,
                                      input logic fn, input logic dn, input logic hl,
                                      input logic [3:0] fw);
        return {ph, pc, fh, fn, dn, hl, fw};
    endfunction

    function automatic logic [9:0] e_idle(input logic [3:0] fw);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fw);
    endfunction

    function automatic logic [9:0] e_stall(input logic [3:0] fw);
        return ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, fw);
    endfunction

    function automatic logic [9:0] e_halt(input logic hl);
        return ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, hl, 4'h0);
    endfunction

    // Stalls only in the build without forwarding.
    function automatic logic [9:0] e_dep(input logic [3:0] fw);
        return FWD ? e_idle(fw) : e_stall(fw);
    endfunction

    function automatic logic [3:0] fw_if(input logic [3:0] fw);
        return FWD ? fw : 4'h0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        rst         = 1'b0;
        halt_req    = 1'b0;
        br_taken    = 1'b0;
        mem_busy    = 1'b0;
        id_src_idx  = '0;
        id_src_vld  = '0;
        ex_mem_read = 1'b0;
        ex_wr_en    = 1'b0;
        ex_rd       = '0;
        mem_wr_en   = 1'b0;
        mem_rd      = '0;
    endtask

    task automatic src(input int i, input logic [REG_W-1:0] r);
        id_src_idx[i*REG_W +: REG_W] = r;
        id_src_vld[i]                = 1'b1;
    endtask

    task automatic ex_w(input logic load, input logic [REG_W-1:0] r);
        ex_mem_read = load;
        ex_wr_en    = 1'b1;
        ex_rd       = r;
    endtask

    task automatic mem_w(input logic [REG_W-1:0] r);
        mem_wr_en = 1'b1;
        mem_rd    = r;
    endtask

    // Inputs are set before the call; expectation covers the current cycle.
    task automatic step(input logic [9:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        idle();
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
    end

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e_cur = exp_q.pop_front();
            n_cur = name_q.pop_front();
            n_tests++;
            if (obs !== e_cur) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (ph pc fh fn dn hl fwd)", n_cur, obs, e_cur);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;

        rst = 1'b1; halt_req = 1'b1; br_taken = 1'b1; mem_busy = 1'b1;
        ex_w(1'b1, 3'd3); src(0, 3'd3);
        step(e_idle(4'h0), "reset_a");
        rst = 1'b1; br_taken = 1'b1; ex_w(1'b0, 3'd2); src(0, 3'd2);
        step(e_idle(4'h0), "reset_b");
        step(e_idle(4'h0), "post_reset");

        // load-use on r3
        ex_w(1'b1, 3'd3); src(0, 3'd3);
        step(e_stall(4'h0), "ld_use_a");
        mem_w(3'd3); src(0, 3'd3);
        step(e_dep(4'h0), "ld_use_b");
        step(e_idle(fw_if(4'b0010)), "ld_use_fwd");
        step(e_idle(4'h0), "ld_use_d");

        // add r2 in EX; ID reads r2 and r0
        ex_w(1'b0, 3'd2); src(0, 3'd2); src(1, 3'd0);
        step(e_dep(4'h0), "add_ex_a");
        mem_w(3'd2); src(0, 3'd2); src(1, 3'd0);
        step(e_dep(fw_if(4'b0001)), "add_ex_b");
        step(e_idle(fw_if(4'b0010)), "add_ex_c");
        step(e_idle(4'h0), "add_ex_d");

        // r0 and invalid sources never hazard; EX beats MEM
        ex_w(1'b1, 3'd0); src(0, 3'd0);
        step(e_idle(4'h0), "r0_load");
        ex_w(1'b1, 3'd5); id_src_idx[2:0] = 3'd5;
        step(e_idle(4'h0), "src_invalid");
        ex_w(1'b0, 3'd4); mem_w(3'd4); src(1, 3'd4);
        step(e_dep(4'h0), "nearest_a");
        step(e_idle(fw_if(4'b0100)), "nearest_b");
        step(e_idle(4'h0), "nearest_c");

        // taken branch, second branch and data hazard ignored during flush
        br_taken = 1'b1;
        step(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0), "br_c0");
        br_taken = 1'b1; ex_w(1'b1, 3'd3); src(0, 3'd3);
        step(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0), "br_c1");
        step(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fw_if(4'b0001)), "br_c2");
        step(e_idle(4'h0), "br_done");

        // mem_busy for 4 cycles in the middle of a flush
        br_taken = 1'b1;
        step(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0), "mw_br_c0");
        step(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0), "mw_br_c1");
        mem_busy = 1'b1;
        step(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0), "mw_busy1");
        mem_busy = 1'b1; br_taken = 1'b1;
        step(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0), "mw_busy2");
        mem_busy = 1'b1;
        step(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0), "mw_busy3");
        mem_busy = 1'b1;
        step(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0), "mw_busy4");
        step(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0), "mw_flush_last");
        step(e_idle(4'h0), "mw_done");

        // mem_busy in RUN: holds the forward select, drops the branch
        ex_w(1'b0, 3'd2); src(0, 3'd2);
        step(e_dep(4'h0), "busy_run_p");
        mem_busy = 1'b1;
        step(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fw_if(4'b0001)), "busy_run_a");
        mem_busy = 1'b1; br_taken = 1'b1;
        step(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fw_if(4'b0001)), "busy_run_b");
        step(e_idle(fw_if(4'b0001)), "busy_run_c");
        step(e_idle(4'h0), "busy_run_d");

        // halt drain, then reset out of HALT
        halt_req = 1'b1;
        step(e_halt(1'b0), "halt_c0");
        step(e_halt(1'b0), "halt_c1");
        br_taken = 1'b1; mem_busy = 1'b1;
        step(e_halt(1'b0), "halt_c2");
        step(e_halt(1'b0), "halt_c3");
        step(e_halt(1'b1), "halted_c4");
        halt_req = 1'b1;
        step(e_halt(1'b1), "halted_c5");
        rst = 1'b1;
        step(e_idle(4'h0), "halt_rst");
        step(e_idle(4'h0), "halt_after_rst");

        // halt together with a taken branch is wrong-path
        halt_req = 1'b1; br_taken = 1'b1;
        step(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0), "hb_c0");
        halt_req = 1'b1;
        step(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0), "hb_c1");
        step(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0), "hb_c2");
        step(e_idle(4'h0), "hb_c3");
        step(e_idle(4'h0), "hb_c4");

        // reset aborts a memory wait saved from FLUSH
        br_taken = 1'b1;
        step(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0), "rmw_br");
        mem_busy = 1'b1;
        step(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0), "rmw_busy");
        rst = 1'b1; mem_busy = 1'b1;
        step(e_idle(4'h0), "rmw_rst");
        step(e_idle(4'h0), "rmw_after");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
